// File: rtl/sdram_avm_bridge.sv
// sdram_avm_bridge
// Turns memory_control's level read/write strobes and bit addresses into single
// Avalon-MM master transactions, one outstanding at a time, and returns read data.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   read, readaddress   read strobe (rising edge = request) and bit address
//   write, writeaddress write strobe (rising edge = request) and bit address
//   writedata           write data, sampled with the write edge
//   readdata            last returned read word, held until the next read completes
//   rd_valid            one-cycle pulse: readdata updated (or read aborted on timeout)
//   wr_ack              one-cycle pulse: write accepted by the controller
//   busy                transaction in progress or a request waiting in a slot
//   err                 sticky error flag, cleared only by reset
//   avm_*               Avalon-MM master towards the SDRAM controller

module sdram_avm_bridge #(
    parameter int unsigned W          = 16,
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned WORD_SHIFT = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         read,
    input  logic [ADDR_W-1:0]            readaddress,
    input  logic                         write,
    input  logic [ADDR_W-1:0]            writeaddress,
    input  logic [W-1:0]                 writedata,
    output logic [W-1:0]                 readdata,
    output logic                         rd_valid,
    output logic                         wr_ack,
    output logic                         busy,
    output logic                         err,
    output logic [ADDR_W-WORD_SHIFT-1:0] avm_address,
    output logic                         avm_read,
    output logic                         avm_write,
    output logic [W-1:0]                 avm_writedata,
    output logic [W/8-1:0]               avm_byteenable,
    input  logic                         avm_waitrequest,
    input  logic [W-1:0]                 avm_readdata,
    input  logic                         avm_readdatavalid
);

    localparam int unsigned AW    = ADDR_W - WORD_SHIFT;
    localparam int unsigned BE_W  = W / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_REQ  = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_WR_REQ  = 2'd3;

    logic [1:0]       state, state_nx;
    logic             read_q, write_q;
    logic             rd_edge, wr_edge;
    logic             rd_pend, rd_pend_nx;
    logic [AW-1:0]    rd_addr, rd_addr_nx;
    logic             wr_pend, wr_pend_nx;
    logic [AW-1:0]    wr_addr, wr_addr_nx;
    logic [W-1:0]     wr_data, wr_data_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;

    logic [W-1:0]     readdata_nx;
    logic             rd_valid_nx, wr_ack_nx, busy_nx, err_nx;
    logic [AW-1:0]    avm_address_nx;
    logic             avm_read_nx, avm_write_nx;
    logic [W-1:0]     avm_writedata_nx;
    logic [BE_W-1:0]  avm_byteenable_nx;

    assign rd_edge = read & ~read_q;
    assign wr_edge = write & ~write_q;
    assign cnt_inc = cnt + CNT_W'(1);

    // Next-state, slot and output logic
    always_comb begin
        state_nx          = state;
        rd_pend_nx        = rd_pend;
        rd_addr_nx        = rd_addr;
        wr_pend_nx        = wr_pend;
        wr_addr_nx        = wr_addr;
        wr_data_nx        = wr_data;
        cnt_nx            = cnt;
        readdata_nx       = readdata;
        rd_valid_nx       = 1'b0;
        wr_ack_nx         = 1'b0;
        err_nx            = err;
        avm_address_nx    = avm_address;
        avm_read_nx       = avm_read;
        avm_write_nx      = avm_write;
        avm_writedata_nx  = avm_writedata;
        avm_byteenable_nx = avm_byteenable;
        busy_nx           = 1'b0;

        // Capture requests; an edge into a full slot is dropped and flagged
        if (rd_edge) begin
            if (rd_pend) begin
                err_nx = 1'b1;
            end else begin
                rd_pend_nx = 1'b1;
                rd_addr_nx = readaddress[ADDR_W-1:WORD_SHIFT];
                if (|readaddress[WORD_SHIFT-1:0]) err_nx = 1'b1;
            end
        end
        if (wr_edge) begin
            if (wr_pend) begin
                err_nx = 1'b1;
            end else begin
                wr_pend_nx = 1'b1;
                wr_addr_nx = writeaddress[ADDR_W-1:WORD_SHIFT];
                wr_data_nx = writedata;
                if (|writeaddress[WORD_SHIFT-1:0]) err_nx = 1'b1;
            end
        end

        if (avm_readdatavalid && (state != S_RD_WAIT)) err_nx = 1'b1;

        // Slot *_nx values include a same-cycle edge, so IDLE issues without an extra cycle
        case (state)
            S_IDLE: begin
                if (wr_pend_nx) begin
                    state_nx          = S_WR_REQ;
                    wr_pend_nx        = 1'b0;
                    avm_write_nx      = 1'b1;
                    avm_address_nx    = wr_addr_nx;
                    avm_writedata_nx  = wr_data_nx;
                    avm_byteenable_nx = '1;
                end else if (rd_pend_nx) begin
                    state_nx       = S_RD_REQ;
                    rd_pend_nx     = 1'b0;
                    avm_read_nx    = 1'b1;
                    avm_address_nx = rd_addr_nx;
                end
            end
            S_WR_REQ: begin
                if (!avm_waitrequest) begin
                    state_nx          = S_IDLE;
                    avm_write_nx      = 1'b0;
                    avm_byteenable_nx = '0;
                    wr_ack_nx         = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (!avm_waitrequest) begin
                    state_nx    = S_RD_WAIT;
                    avm_read_nx = 1'b0;
                    cnt_nx      = '0;
                end
            end
            S_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    state_nx    = S_IDLE;
                    readdata_nx = avm_readdata;
                    rd_valid_nx = 1'b1;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    // Abort: release upstream with old readdata
                    state_nx    = S_IDLE;
                    rd_valid_nx = 1'b1;
                    err_nx      = 1'b1;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        busy_nx = (state_nx != S_IDLE) | rd_pend_nx | wr_pend_nx;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            read_q         <= 1'b0;
            write_q        <= 1'b0;
            rd_pend        <= 1'b0;
            rd_addr        <= '0;
            wr_pend        <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            cnt            <= '0;
            readdata       <= '0;
            rd_valid       <= 1'b0;
            wr_ack         <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            state          <= state_nx;
            read_q         <= read;
            write_q        <= write;
            rd_pend        <= rd_pend_nx;
            rd_addr        <= rd_addr_nx;
            wr_pend        <= wr_pend_nx;
            wr_addr        <= wr_addr_nx;
            wr_data        <= wr_data_nx;
            cnt            <= cnt_nx;
            readdata       <= readdata_nx;
            rd_valid       <= rd_valid_nx;
            wr_ack         <= wr_ack_nx;
            busy           <= busy_nx;
            err            <= err_nx;
            avm_address    <= avm_address_nx;
            avm_read       <= avm_read_nx;
            avm_write      <= avm_write_nx;
            avm_writedata  <= avm_writedata_nx;
            avm_byteenable <= avm_byteenable_nx;
        end
    end

endmodule
